// File: rtl/sum_pkg.sv
// Shared definitions for the sum_N producer and the sum_collector consumer.
package sum_pkg;

  // Width of one accumulated result from sum_N.
  localparam int SUM_W = 5;

  // Capture handshake states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate occupancy counter. The head is
// shown combinationally and forced to zero while empty so the output is
// well defined out of reset.
module sync_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                 (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  // Both checks use pre-edge occupancy: a same-edge pop never admits a push into a full FIFO.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign dout = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Pointer advance; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
  end

endmodule

// File: rtl/sum_collector.sv
// Consumer of the sum_N accumulator: captures each result over the
// valid/ack handshake, queues it for the next stage, and keeps a
// saturating running total plus a wrapping capture count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for sum_valid_in with room in the FIFO; captures here
// ACK      | sum_ack high for this single cycle
// WAIT_LOW | producer still holding valid; wait for it to drop
module sum_collector #(
  parameter int SUM_W   = sum_pkg::SUM_W,
  parameter int DEPTH   = 4,
  parameter int TOTAL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SUM_W-1:0]   sum_in,
  input  logic               sum_valid_in,
  output logic               sum_ack,
  output logic [SUM_W-1:0]   data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic [TOTAL_W-1:0] total_out,
  output logic [CNT_W-1:0]   count_out
);

  import sum_pkg::*;

  cap_state_t         r_state;
  cap_state_t         w_state_next;
  logic               w_capture;
  logic               r_sum_ack;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_pop;
  logic [TOTAL_W-1:0] r_total;
  logic [TOTAL_W:0]   w_total_wide;
  logic [TOTAL_W-1:0] w_total_next;
  logic [CNT_W-1:0]   r_count;

  // Capture-state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and capture decode; WAIT_LOW guarantees a held valid is taken only once.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (sum_valid_in && !w_fifo_full) begin
          w_capture    = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK: begin
        w_state_next = sum_valid_in ? WAIT_LOW : IDLE;
      end
      WAIT_LOW: begin
        if (!sum_valid_in) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Acknowledge registered from the capture edge so it is high exactly in the ACK cycle.
  always_ff @(posedge clk) begin
    if (reset) r_sum_ack <= 1'b0;
    else       r_sum_ack <= w_capture;
  end

  assign sum_ack = r_sum_ack;

  // Saturating add: one extra bit catches the carry, which clamps to all ones.
  assign w_total_wide = {1'b0, r_total} + {{(TOTAL_W + 1 - SUM_W){1'b0}}, sum_in};
  assign w_total_next = w_total_wide[TOTAL_W] ? {TOTAL_W{1'b1}} : w_total_wide[TOTAL_W-1:0];

  // Running total and capture count, both updated on the capture edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_total <= '0;
      r_count <= '0;
    end else if (w_capture) begin
      r_total <= w_total_next;
      r_count <= r_count + 1'b1;
    end
  end

  assign total_out = r_total;
  assign count_out = r_count;

  assign w_pop      = data_ready && !w_fifo_empty;
  assign data_valid = !w_fifo_empty;

  sync_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_capture),
    .pop   (w_pop),
    .din   (sum_in),
    .dout  (data_out),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

endmodule

// File: tb/tb_sum_collector.sv
// Directed bench for sum_collector: a scoreboard queue holds expected
// output words and a negedge monitor checks each pop against it.
module tb_sum_collector;

  logic       clk;
  logic       reset;
  logic [4:0] sum_in;
  logic       sum_valid_in;
  logic       sum_ack;
  logic [4:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] total_out;
  logic [7:0] count_out;

  int n_checks = 0;
  int n_pass   = 0;
  int sb_q[$];

  sum_collector dut (
    .clk          (clk),
    .reset        (reset),
    .sum_in       (sum_in),
    .sum_valid_in (sum_valid_in),
    .sum_ack      (sum_ack),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .total_out    (total_out),
    .count_out    (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: a pop happens on the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && data_valid && data_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got %0d with no expected entry", data_out);
      end else begin
        check("sb_data", int'(data_out), sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    data_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
  endtask

  // Present one result, wait for its ack, release valid, and settle back in IDLE.
  task automatic send(input int v, output int waited);
    sum_in       = 5'(v);
    sum_valid_in = 1'b1;
    sb_q.push_back(v);
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      waited++;
      if (sum_ack) break;
    end
    if (!sum_ack) check("send_ack_timeout", 0, 1);
    sum_valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    data_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!data_valid) break;
      @(posedge clk); #1;
    end
    data_ready = 1'b0;
    check("drain_empty", int'(data_valid), 0);
    check("drain_sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int acks;
    int vals2[4] = '{1, 3, 6, 10};
    int vals5[4] = '{7, 9, 2, 31};
    reset = 1'b1; sum_in = '0; sum_valid_in = 1'b0; data_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // 1: reset state, then a single capture of 28
    check("rst_ack", int'(sum_ack), 0);
    check("rst_valid", int'(data_valid), 0);
    check("rst_dout", int'(data_out), 0);
    check("rst_total", int'(total_out), 0);
    check("rst_count", int'(count_out), 0);
    send(28, w);
    check("t1_ack_lat", w, 1);
    check("t1_ack_pulse", int'(sum_ack), 0);
    check("t1_valid", int'(data_valid), 1);
    check("t1_dout", int'(data_out), 28);
    check("t1_total", int'(total_out), 28);
    check("t1_count", int'(count_out), 1);
    drain();

    // 2: back-pressure with a full FIFO
    do_reset();
    foreach (vals2[i]) begin
      send(vals2[i], w);
      check("t2_ack_lat", w, 1);
    end
    sum_in = 5'd15; sum_valid_in = 1'b1; sb_q.push_back(15);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (sum_ack) acks++;
    end
    check("t2_full_no_ack", acks, 0);
    check("t2_head_held", int'(data_out), 1);
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    w = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      w++;
      if (sum_ack) break;
    end
    check("t2_ack_after_pop", w, 1);
    sum_valid_in = 1'b0;
    @(posedge clk); #1;
    check("t2_count", int'(count_out), 5);
    drain();

    // 3: valid held high long after its ack
    do_reset();
    sum_in = 5'd5; sum_valid_in = 1'b1; sb_q.push_back(5);
    acks = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (sum_ack) acks++;
    end
    check("t3_one_ack", acks, 1);
    check("t3_count", int'(count_out), 1);
    sum_valid_in = 1'b0;
    @(posedge clk); #1;
    drain();

    // 4: saturation of the running total
    do_reset();
    data_ready = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      send(28, w);
      if (i == 9) check("t4_total_9", int'(total_out), 252);
      if (i == 10) begin
        check("t4_total_10", int'(total_out), 255);
        check("t4_count_10", int'(count_out), 10);
      end
      if (i == 11) begin
        check("t4_total_11", int'(total_out), 255);
        check("t4_count_11", int'(count_out), 11);
      end
    end
    drain();

    // 5: ready held high; occupancy never exceeds one, then a same-edge push and pop
    do_reset();
    data_ready = 1'b1;
    foreach (vals5[i]) begin
      send(vals5[i], w);
      check("t5_occ_le1", int'(data_valid), 0);
    end
    data_ready = 1'b0;
    send(17, w);
    sum_in = 5'd22; sum_valid_in = 1'b1; data_ready = 1'b1; sb_q.push_back(22);
    @(posedge clk); #1;
    check("t5_pp_ack", int'(sum_ack), 1);
    data_ready = 1'b0; sum_valid_in = 1'b0;
    check("t5_pp_valid", int'(data_valid), 1);
    check("t5_pp_dout", int'(data_out), 22);
    @(posedge clk); #1;
    drain();

    // 6: reset during the ACK cycle
    do_reset();
    sum_in = 5'd20; sum_valid_in = 1'b1; sb_q.push_back(20);
    @(posedge clk); #1;
    check("t6_in_ack", int'(sum_ack), 1);
    sum_valid_in = 1'b0;
    do_reset();
    check("t6_ack", int'(sum_ack), 0);
    check("t6_valid", int'(data_valid), 0);
    check("t6_dout", int'(data_out), 0);
    check("t6_total", int'(total_out), 0);
    check("t6_count", int'(count_out), 0);
    send(9, w);
    check("t6_new_lat", w, 1);
    check("t6_new_total", int'(total_out), 9);
    check("t6_new_count", int'(count_out), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
